// File: rtl/led_frame_sequencer.sv
// -----------------------------------------------------------------------------
// led_frame_sequencer
//
// Purpose:
//   Drives a MAX7219-style LED matrix controller through a byte-oriented SPI
//   master. Each register write is a two-byte CS window: an address byte
//   followed by a data byte. On a start request the block optionally replays
//   the controller init list (shutdown, display-test off, no decode, scan
//   limit, intensity, normal operation). It then streams one frame by reading
//   rows 0..NUM_ROWS-1 from an external framebuffer and writing them to the
//   digit registers 1..NUM_ROWS.
//
// Parameters:
//   NUM_ROWS   - number of display rows (1..8), register addresses 1..NUM_ROWS
//   SCAN_LIMIT - data byte written to the scan-limit register (0x0B)
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-low reset
//   start         in   one-cycle frame refresh request (accepted only when idle)
//   init_req      in   one-cycle request to replay the init list before the
//                      next frame (accepted in any state)
//   intensity     in   4-bit brightness, sampled when its data byte is strobed
//   fb_addr       out  framebuffer row read address
//   fb_data       in   framebuffer row data, valid one cycle after fb_addr
//   spi_num_bytes out  bytes per CS window, constant 2
//   spi_tx_byte   out  byte to the SPI master, held until the next strobe
//   spi_tx_dv     out  one-cycle strobe qualifying spi_tx_byte
//   spi_tx_ready  in   SPI master can take a byte
//   busy          out  high while a sequence is in progress (through DONE)
//   done          out  one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module led_frame_sequencer #(
    parameter int         NUM_ROWS   = 8,
    parameter logic [7:0] SCAN_LIMIT = 8'h07
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       init_req,
    input  logic [3:0] intensity,
    output logic [2:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic [1:0] spi_num_bytes,
    output logic [7:0] spi_tx_byte,
    output logic       spi_tx_dv,
    input  logic       spi_tx_ready,
    output logic       busy,
    output logic       done
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] INIT_LOAD  = 4'd1;
    localparam logic [3:0] FRAME_LOAD = 4'd2;
    localparam logic [3:0] SEND_ADDR  = 4'd3;
    localparam logic [3:0] GUARD_ADDR = 4'd4;
    localparam logic [3:0] SEND_DATA  = 4'd5;
    localparam logic [3:0] GUARD_DATA = 4'd6;
    localparam logic [3:0] NEXT       = 4'd7;
    localparam logic [3:0] DONE       = 4'd8;

    // Last row index; the row counter saturates here and never wraps to 0.
    localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);
    // Six entries in the init list, indices 0..5.
    localparam logic [2:0] INIT_LAST = 3'd5;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [3:0] state_q,        state_d;
    logic       init_pending_q, init_pending_d;
    logic       init_again_q,   init_again_d;   // init_req seen while init runs
    logic       in_init_q,      in_init_d;      // 1: walking the init list
    logic [2:0] init_idx_q,     init_idx_d;
    logic [2:0] row_q,          row_d;
    logic [2:0] fb_addr_q,      fb_addr_d;
    logic [7:0] addr_byte_q,    addr_byte_d;    // address byte of the pending write
    logic [7:0] spi_tx_byte_q,  spi_tx_byte_d;
    logic       spi_tx_dv_q,    spi_tx_dv_d;

    // -------------------------------------------------------------------------
    // Init list lookup. The intensity entry is combinational on purpose so the
    // value on the pins at the moment of the data strobe is the one sent.
    // -------------------------------------------------------------------------
    logic [7:0] init_addr;
    logic [7:0] init_data;

    always_comb begin
        init_addr = 8'h0C;
        init_data = 8'h01;
        case (init_idx_q)
            3'd0: begin init_addr = 8'h0C; init_data = 8'h00;               end
            3'd1: begin init_addr = 8'h0F; init_data = 8'h00;               end
            3'd2: begin init_addr = 8'h09; init_data = 8'h00;               end
            3'd3: begin init_addr = 8'h0B; init_data = SCAN_LIMIT;          end
            3'd4: begin init_addr = 8'h0A; init_data = {4'h0, intensity};   end
            default: begin init_addr = 8'h0C; init_data = 8'h01;            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        init_pending_d = init_pending_q;
        init_again_d   = init_again_q;
        in_init_d      = in_init_q;
        init_idx_d     = init_idx_q;
        row_d          = row_q;
        fb_addr_d      = fb_addr_q;
        addr_byte_d    = addr_byte_q;
        spi_tx_byte_d  = spi_tx_byte_q;
        spi_tx_dv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d      = 3'd0;
                    init_idx_d = 3'd0;
                    if (init_pending_q) begin
                        in_init_d = 1'b1;
                        state_d   = INIT_LOAD;
                    end else begin
                        in_init_d = 1'b0;
                        state_d   = FRAME_LOAD;
                    end
                end
            end

            INIT_LOAD: begin
                addr_byte_d = init_addr;
                state_d     = SEND_ADDR;
            end

            FRAME_LOAD: begin
                // The row address goes out here, several cycles ahead of the
                // data strobe, so a registered-read framebuffer has settled.
                fb_addr_d   = row_q;
                addr_byte_d = {5'b0_0000, row_q} + 8'd1;
                state_d     = SEND_ADDR;
            end

            SEND_ADDR: begin
                if (spi_tx_ready) begin
                    spi_tx_byte_d = addr_byte_q;
                    spi_tx_dv_d   = 1'b1;
                    state_d       = GUARD_ADDR;
                end
            end

            GUARD_ADDR: begin
                // While the strobe is still on the pins the master has not yet
                // reacted, so its ready is stale and must be ignored.
                if (!spi_tx_dv_q && spi_tx_ready) begin
                    state_d = SEND_DATA;
                end
            end

            SEND_DATA: begin
                if (spi_tx_ready) begin
                    spi_tx_byte_d = in_init_q ? init_data : fb_data;
                    spi_tx_dv_d   = 1'b1;
                    state_d       = GUARD_DATA;
                end
            end

            GUARD_DATA: begin
                if (!spi_tx_dv_q && spi_tx_ready) begin
                    state_d = NEXT;
                end
            end

            NEXT: begin
                if (in_init_q) begin
                    if (init_idx_q == INIT_LAST) begin
                        in_init_d = 1'b0;
                        row_d     = 3'd0;
                        state_d   = FRAME_LOAD;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        state_d    = INIT_LOAD;
                    end
                end else if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 3'd1;
                    state_d = FRAME_LOAD;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Init request bookkeeping. A request that lands while the init list is
        // already being replayed is parked in init_again so that clearing the
        // pending flag at the end of init does not swallow it.
        if (state_q == NEXT && in_init_q && init_idx_q == INIT_LAST) begin
            init_pending_d = init_again_q | init_req;
            init_again_d   = 1'b0;
        end else if (init_req) begin
            if (in_init_d) begin
                init_again_d = 1'b1;
            end else begin
                init_pending_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            init_pending_q <= 1'b1;
            init_again_q   <= 1'b0;
            in_init_q      <= 1'b0;
            init_idx_q     <= 3'd0;
            row_q          <= 3'd0;
            fb_addr_q      <= 3'd0;
            addr_byte_q    <= 8'h00;
            spi_tx_byte_q  <= 8'h00;
            spi_tx_dv_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_pending_q <= init_pending_d;
            init_again_q   <= init_again_d;
            in_init_q      <= in_init_d;
            init_idx_q     <= init_idx_d;
            row_q          <= row_d;
            fb_addr_q      <= fb_addr_d;
            addr_byte_q    <= addr_byte_d;
            spi_tx_byte_q  <= spi_tx_byte_d;
            spi_tx_dv_q    <= spi_tx_dv_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fb_addr       = fb_addr_q;
    assign spi_num_bytes = 2'b10;
    assign spi_tx_byte   = spi_tx_byte_q;
    assign spi_tx_dv     = spi_tx_dv_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_frame_sequencer
//
// Self-checking bench for led_frame_sequencer. A framebuffer with registered
// read and an SPI master whose ready drops for a random number of cycles after
// each strobe surround the DUT. Captured strobed bytes are compared with a
// reference byte list built directly from the register-write rules.
// -----------------------------------------------------------------------------
module tb_led_frame_sequencer;

    localparam int         NUM_ROWS   = 8;
    localparam logic [7:0] SCAN_LIMIT = 8'h07;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       init_req = 1'b0;
    logic [3:0] intensity = 4'h0;
    logic [2:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic [1:0] spi_num_bytes;
    logic [7:0] spi_tx_byte;
    logic       spi_tx_dv;
    logic       spi_tx_ready;
    logic       busy;
    logic       done;

    led_frame_sequencer #(
        .NUM_ROWS   (NUM_ROWS),
        .SCAN_LIMIT (SCAN_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .init_req      (init_req),
        .intensity     (intensity),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .spi_num_bytes (spi_num_bytes),
        .spi_tx_byte   (spi_tx_byte),
        .spi_tx_dv     (spi_tx_dv),
        .spi_tx_ready  (spi_tx_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Framebuffer: registered read, data valid one cycle after the address.
    logic [7:0] fb_mem [8];
    always @(posedge clk) fb_data <= fb_mem[fb_addr];

    // SPI master model: busy for 0..3 cycles after each strobe, plus a forced
    // not-ready window controlled by the stimulus.
    int   spi_busy_cnt = 0;
    logic hold_low = 1'b0;
    always @(posedge clk) begin
        if (!reset)             spi_busy_cnt <= 0;
        else if (spi_tx_dv)     spi_busy_cnt <= int'($urandom_range(0, 3));
        else if (spi_busy_cnt > 0) spi_busy_cnt <= spi_busy_cnt - 1;
    end
    assign spi_tx_ready = (spi_busy_cnt == 0) && !hold_low;

    // Bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: capture strobed bytes, count done pulses, check strobe rules.
    logic [7:0] got_q [$];
    int         done_cnt = 0;
    logic       prev_dv = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (spi_tx_dv) begin
                chk("dv_back_to_back", int'(prev_dv), 0);
                chk("dv_while_ready_forced_low", int'(hold_low), 0);
                got_q.push_back(spi_tx_byte);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_dv <= spi_tx_dv;
    end

    // Reference model: the list of bytes a frame must produce.
    logic [7:0] exp_q [$];
    bit         model_pending = 1'b1;

    function automatic void build_expected(input bit with_init, input logic [3:0] inten);
        logic [7:0] init_list [12];
        init_list = '{8'h0C, 8'h00, 8'h0F, 8'h00, 8'h09, 8'h00,
                      8'h0B, SCAN_LIMIT, 8'h0A, 8'h00, 8'h0C, 8'h01};
        init_list[9] = {4'h0, inten};
        exp_q.delete();
        if (with_init) begin
            for (int i = 0; i < 12; i++) exp_q.push_back(init_list[i]);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            exp_q.push_back(8'(r + 1));
            exp_q.push_back(fb_mem[r]);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk({name, "_dv"},        int'(spi_tx_dv), 0);
        chk({name, "_busy"},      int'(busy), 0);
        chk({name, "_done"},      int'(done), 0);
        chk({name, "_tx_byte"},   int'(spi_tx_byte), 0);
        chk({name, "_fb_addr"},   int'(fb_addr), 0);
        chk({name, "_num_bytes"}, int'(spi_num_bytes), 2);
    endtask

    task automatic wait_bytes(input int n, input string name);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        chk({name, "_bytes_timeout"}, int'(k < 3000), 1);
    endtask

    task automatic wait_done(input int base, input string name);
        int k = 0;
        while (done_cnt == base && k < 3000) begin
            tick();
            k++;
        end
        chk({name, "_done_timeout"}, int'(k < 3000), 1);
    endtask

    task automatic compare_run(input string name);
        int n;
        chk({name, "_len_vs_model"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
        end
    endtask

    typedef struct {
        logic [3:0] inten;
        bit         init_req_before;
        bit         init_req_mid;
        bit         start_mid;
        bit         hold_mid;
        bit         rand_fb;
        bit         immediate;   // next start follows done with no idle gap
        int         exp_len;     // -1: take the length from the model only
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        int base;
        int s;
        if (v.rand_fb) begin
            for (int r = 0; r < 8; r++) fb_mem[r] = 8'($urandom_range(0, 255));
        end
        if (v.init_req_before) begin
            init_req = 1'b1;
            tick();
            init_req = 1'b0;
            model_pending = 1'b1;
        end
        intensity = v.inten;
        build_expected(model_pending, v.inten);
        model_pending = 1'b0;
        got_q.delete();
        base = done_cnt;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_busy_after_start"}, int'(busy), 1);

        if (v.init_req_mid || v.start_mid || v.hold_mid) begin
            wait_bytes(13, name);
            if (v.init_req_mid) begin
                init_req = 1'b1;
                tick();
                init_req = 1'b0;
                model_pending = 1'b1;
            end
            if (v.start_mid) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (v.hold_mid) begin
                hold_low = 1'b1;
                s = got_q.size();
                repeat (50) tick();
                chk({name, "_no_strobe_in_hold"}, got_q.size(), s);
                hold_low = 1'b0;
            end
        end

        wait_done(base, name);
        if (!v.immediate) repeat (20) tick();
        chk({name, "_done_count"}, done_cnt - base, 1);
        if (v.exp_len >= 0) chk({name, "_len"}, got_q.size(), v.exp_len);
        compare_run(name);
    endtask

    vec_t vecs [6];

    initial begin
        int base;
        vec_t rv;

        //          inten  ireq_b ireq_m st_m hold rfb  imm  len
        vecs[0] = '{4'h5,  1'b0,  1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 28};
        vecs[1] = '{4'h5,  1'b0,  1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 16};
        vecs[2] = '{4'h9,  1'b0,  1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16};
        vecs[3] = '{4'h3,  1'b0,  1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 28};
        vecs[4] = '{4'hA,  1'b0,  1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 16};
        vecs[5] = '{4'hF,  1'b1,  1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 28};

        for (int r = 0; r < 8; r++) fb_mem[r] = 8'(1 << r);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset_initial");
        reset = 1'b1;
        model_pending = 1'b1;
        repeat (2) tick();

        // Directed table
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset right after the fifth strobe of a frame
        got_q.delete();
        base = done_cnt;
        intensity = 4'h2;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bytes(5, "rst_mid");
        reset = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (3) tick();
        reset = 1'b1;
        model_pending = 1'b1;
        repeat (20) tick();
        chk("rst_mid_no_more_strobes", got_q.size(), 5);
        chk("rst_mid_no_done", done_cnt - base, 0);
        rv = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28};
        run_vec(rv, "after_rst");

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            rv.inten           = 4'($urandom_range(0, 15));
            rv.init_req_before = ($urandom_range(0, 2) == 0);
            rv.init_req_mid    = ($urandom_range(0, 3) == 0);
            rv.start_mid       = ($urandom_range(0, 1) == 0);
            rv.hold_mid        = ($urandom_range(0, 3) == 0);
            rv.rand_fb         = 1'b1;
            rv.immediate       = ($urandom_range(0, 1) == 0);
            rv.exp_len         = -1;
            run_vec(rv, $sformatf("rand%0d", i));
        end

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
